mv_operand_loader: RTL and testbench
====================================

Name: mv_operand_loader

Overview:
- Upstream feeder for the TensorUnit matrix-vector multiplier.
- Accepts a stream of IEEE-754 float32 words, one per beat: M_SIZE*M_SIZE matrix elements in row-major order, then M_SIZE vector elements.
- Assembles the words into the flat matrix and vector buses and presents them to TensorUnit with a valid/ready handshake.
- Single-buffered: accepts no new frame until the current one has been handed off.

Parameters:
- D_WIDTH, 32, element width in bits (float32).
- M_SIZE, 10, matrix dimension (square M_SIZE x M_SIZE) and vector length.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  reset, asynchronous assert, active-low.
- s_tdata  in  D_WIDTH  stream element.
- s_tvalid  in  1  stream word valid.
- s_tready  out  1  loader can accept a word.
- s_tlast  in  1  marks the final word of a frame.
- o_matrix  out  D_WIDTH*M_SIZE*M_SIZE  flat matrix to TensorUnit i_matrix.
- o_vector  out  D_WIDTH*M_SIZE  flat vector to TensorUnit i_vector.
- o_matrix_is_valid  out  1  to TensorUnit i_matrix_is_valid.
- o_vector_is_valid  out  1  to TensorUnit i_vector_is_valid.
- i_ready_to_accept_matrix  in  1  from TensorUnit.
- i_ready_to_accept_vector  in  1  from TensorUnit.
- o_frame_error  out  1  one-cycle pulse on a framing error.

Behaviour:
- Clocking and reset: one clock, aclk; reset aresetn is asynchronous and active-low.
- Reset values: o_matrix=0, o_vector=0, both valids=0, s_tready=0, o_frame_error=0, state=LOAD_M, counter=0.
- First edge after reset release: s_tready goes 1.
- Word accept: a word is taken on a rising edge when s_tvalid & s_tready.
- Packing: the first word of the frame lands in the most-significant slot. Element k (0-based within its bus of N elements) occupies bits [D_WIDTH*(N-k)-1 -: D_WIDTH]. Matrix element (r,c) therefore has k = r*M_SIZE + c. Data is stored verbatim; no arithmetic.
- LOAD_M: s_tready=1. Each accepted word is written to matrix slot cnt, then cnt++. After word M_SIZE*M_SIZE-1: cnt<=0, go to LOAD_V.
- LOAD_V: s_tready=1. Each accepted word is written to vector slot cnt. After word M_SIZE-1: go to PRESENT.
- Entering PRESENT: both valids go 1 on the same edge that accepts the last word, so latency is 0 cycles after the final beat. s_tready goes 0 on that edge.
- PRESENT: valids are held high and o_matrix/o_vector are held stable. Hand-off occurs on an edge where i_ready_to_accept_matrix & i_ready_to_accept_vector are both 1. On that edge both valids go 0 together, s_tready goes 1, state goes to LOAD_M with cnt=0. One ready without the other does not complete the hand-off; the block keeps waiting.
- Bus contents after hand-off: o_matrix/o_vector keep their old contents until overwritten slot by slot by the next frame. Consumers sample only at hand-off.
- Framing rules:
  - s_tlast on any word other than the final vector word: pulse o_frame_error, discard the partial frame, go to LOAD_M with cnt=0. Slots already written are left stale.
  - Final vector word without s_tlast: pulse o_frame_error and go to DRAIN, with no valid asserted.
  - DRAIN: s_tready=1; words are discarded until a word with s_tlast is accepted, then go to LOAD_M.
- Back-pressure: s_tvalid low mid-frame stalls the load with no timeout; the counter holds.
- Reset mid-operation: immediately returns to the reset values; the partial frame is lost.
- M_SIZE=1 is legal: a frame is 2 words.

Decomposition:
- Package mv_pkg:
  - D_WIDTH and M_SIZE defaults.
  - Derived widths MAT_W, VEC_W, CNT_W = clog2(M_SIZE*M_SIZE).
  - State encoding: LOAD_M, LOAD_V, PRESENT, DRAIN.
  - Float32 constants for benches (FP_ONE=0x3F800000, etc.).
- Single module; no sub-module warranted. The slot-write decode is a generate loop.

Test Plan:
- Nominal 2x2 (M_SIZE=2). Send 0x41000000, 0x40800000, 0x40000000, 0x3F800000, 0x40A00000, 0x40400000(tlast), readies high -> o_matrix=0x41000000_40800000_40000000_3F800000, o_vector=0x40A00000_40400000; valids high for exactly 1 cycle; s_tready low during PRESENT.
- Ready stall. Same frame with i_ready_to_accept_vector low for 5 cycles and matrix ready high -> valids stay high and buses stable for 5 cycles; hand-off on the first cycle both readies are high.
- Early tlast. tlast on word 3 of 6 -> o_frame_error pulses 1 cycle, valids never rise; the next clean frame loads correctly.
- Missing tlast. Frame of 6 words without tlast, then 2 junk words with tlast on the second -> one error pulse, junk discarded; the next frame loads correctly.
- Gapped input and reset. s_tvalid toggling every other cycle -> correct packing. aresetn pulsed low after word 4 of 10x10 -> all outputs 0 immediately; a fresh 110-word frame loads correctly.
- Back-to-back 10x10. Two consecutive 110-word frames with tvalid always high -> exactly one PRESENT per frame; s_tready low only in PRESENT; second buses match the second frame.

Source files
------------

// File: rtl/mv_operand_loader_pkg.sv
// Shared constants, state encoding and float32 bench constants for the
// TensorUnit operand loader.
package mv_pkg;

  localparam int unsigned DEF_D_WIDTH = 32;
  localparam int unsigned DEF_M_SIZE  = 10;

  localparam int unsigned MAT_W = DEF_D_WIDTH * DEF_M_SIZE * DEF_M_SIZE;
  localparam int unsigned VEC_W = DEF_D_WIDTH * DEF_M_SIZE;
  localparam int unsigned CNT_W = $clog2(DEF_M_SIZE * DEF_M_SIZE);

  typedef enum logic [1:0] {
    LOAD_M  = 2'd0,
    LOAD_V  = 2'd1,
    PRESENT = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam logic [31:0] FP_ONE   = 32'h3F80_0000;
  localparam logic [31:0] FP_TWO   = 32'h4000_0000;
  localparam logic [31:0] FP_THREE = 32'h4040_0000;
  localparam logic [31:0] FP_FOUR  = 32'h4080_0000;
  localparam logic [31:0] FP_FIVE  = 32'h40A0_0000;
  localparam logic [31:0] FP_EIGHT = 32'h4100_0000;

  // Slot counter width; a 1x1 matrix still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mv_operand_loader_if.sv
// Element stream (data/valid/ready/last) feeding the operand loader.
interface mv_operand_loader_if #(
  parameter int unsigned D_WIDTH = 32
) ();

  logic [D_WIDTH-1:0] s_tdata;
  logic               s_tvalid;
  logic               s_tready;
  logic               s_tlast;

  modport master (output s_tdata, output s_tvalid, output s_tlast, input s_tready);
  modport slave  (input s_tdata, input s_tvalid, input s_tlast, output s_tready);

endinterface

// File: rtl/mv_operand_loader.sv
// Collects M_SIZE*M_SIZE matrix words then M_SIZE vector words from the
// stream, packs them first-word-most-significant and hands the frame to
// TensorUnit over a valid/ready handshake. Single frame buffer.
module mv_operand_loader
  import mv_pkg::*;
#(
  parameter int unsigned D_WIDTH = DEF_D_WIDTH,
  parameter int unsigned M_SIZE  = DEF_M_SIZE
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  mv_operand_loader_if.slave                s,
  output logic [D_WIDTH*M_SIZE*M_SIZE-1:0]  o_matrix,
  output logic [D_WIDTH*M_SIZE-1:0]         o_vector,
  output logic                              o_matrix_is_valid,
  output logic                              o_vector_is_valid,
  input  logic                              i_ready_to_accept_matrix,
  input  logic                              i_ready_to_accept_vector,
  output logic                              o_frame_error
);

  localparam int unsigned N_MAT = M_SIZE * M_SIZE;
  localparam int unsigned CW    = cnt_width(N_MAT);
  localparam logic [CW-1:0] LAST_M = CW'(N_MAT - 1);
  localparam logic [CW-1:0] LAST_V = CW'(M_SIZE - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            tready_q, tready_d;
  logic            err_q, err_d;
  logic            mat_we, vec_we;
  logic            accept;

  logic [D_WIDTH-1:0] mat_q [N_MAT];
  logic [D_WIDTH-1:0] mat_d [N_MAT];
  logic [D_WIDTH-1:0] vec_q [M_SIZE];
  logic [D_WIDTH-1:0] vec_d [M_SIZE];

  assign accept     = s.s_tvalid & tready_q;
  assign s.s_tready = tready_q;

  // State, counter and registered handshake/error outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= LOAD_M;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      tready_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      tready_q <= tready_d;
      err_q    <= err_d;
    end
  end

  // Next state, slot counter, framing checks and slot-write strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    mat_we  = 1'b0;
    vec_we  = 1'b0;
    unique case (state_q)
      LOAD_M: begin
        if (accept) begin
          if (s.s_tlast) begin
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            mat_we = 1'b1;
            if (cnt_q == LAST_M) begin
              cnt_d   = '0;
              state_d = LOAD_V;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      LOAD_V: begin
        if (accept) begin
          if (cnt_q == LAST_V) begin
            cnt_d = '0;
            if (s.s_tlast) begin
              vec_we  = 1'b1;
              state_d = PRESENT;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end else if (s.s_tlast) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = LOAD_M;
          end else begin
            vec_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end
        end
      end
      PRESENT: begin
        if (i_ready_to_accept_matrix && i_ready_to_accept_vector) begin
          state_d = LOAD_M;
        end
      end
      DRAIN: begin
        if (accept && s.s_tlast) begin
          state_d = LOAD_M;
        end
      end
      default: state_d = LOAD_M;
    endcase
  end

  // Registered outputs follow the upcoming state so valids rise on the
  // edge that takes the final word, with ready dropping on that same edge.
  always_comb begin
    valid_d  = (state_d == PRESENT);
    tready_d = (state_d != PRESENT);
  end

  // Per-slot write decode.
  for (genvar k = 0; k < int'(N_MAT); k++) begin : g_mat
    assign mat_d[k] = (mat_we && (cnt_q == CW'(k))) ? s.s_tdata : mat_q[k];
  end
  for (genvar k = 0; k < int'(M_SIZE); k++) begin : g_vec
    assign vec_d[k] = (vec_we && (cnt_q == CW'(k))) ? s.s_tdata : vec_q[k];
  end

  // Frame buffer; slots keep old contents until rewritten.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mat_q <= '{default: '0};
      vec_q <= '{default: '0};
    end else begin
      mat_q <= mat_d;
      vec_q <= vec_d;
    end
  end

  // Flatten buffers: element k sits at [D_WIDTH*(N-k)-1 -: D_WIDTH].
  always_comb begin
    o_matrix = '0;
    o_vector = '0;
    for (int unsigned k = 0; k < N_MAT; k++) begin
      o_matrix[D_WIDTH*(N_MAT-k)-1 -: D_WIDTH] = mat_q[k];
    end
    for (int unsigned k = 0; k < M_SIZE; k++) begin
      o_vector[D_WIDTH*(M_SIZE-k)-1 -: D_WIDTH] = vec_q[k];
    end
  end

  assign o_matrix_is_valid = valid_q;
  assign o_vector_is_valid = valid_q;
  assign o_frame_error     = err_q;

endmodule

// File: tb/tb_mv_operand_loader.sv
// Directed bench: a 2x2 loader for framing/handshake cases and a 10x10
// loader for reset and back-to-back full-size frames.
module tb_mv_operand_loader;

  logic clk = 1'b0;
  logic rstn;
  logic rdy_m, rdy_v;

  logic [127:0]  m2;
  logic [63:0]   v2;
  logic          mv2, vv2, err2;
  logic [3199:0] m10;
  logic [319:0]  v10;
  logic          mv10, vv10, err10;

  int passed = 0;
  int total  = 0;

  int  pres10 = 0;
  int  viol10 = 0;
  logic mon_en = 1'b0;
  logic mv10_prev = 1'b0;

  mv_operand_loader_if #(.D_WIDTH(32)) bus2 ();
  mv_operand_loader_if #(.D_WIDTH(32)) bus10 ();

  mv_operand_loader #(.D_WIDTH(32), .M_SIZE(2)) dut2 (
    .aclk(clk), .aresetn(rstn), .s(bus2),
    .o_matrix(m2), .o_vector(v2),
    .o_matrix_is_valid(mv2), .o_vector_is_valid(vv2),
    .i_ready_to_accept_matrix(rdy_m), .i_ready_to_accept_vector(rdy_v),
    .o_frame_error(err2)
  );

  mv_operand_loader #(.D_WIDTH(32), .M_SIZE(10)) dut10 (
    .aclk(clk), .aresetn(rstn), .s(bus10),
    .o_matrix(m10), .o_vector(v10),
    .o_matrix_is_valid(mv10), .o_vector_is_valid(vv10),
    .i_ready_to_accept_matrix(rdy_m), .i_ready_to_accept_vector(rdy_v),
    .o_frame_error(err10)
  );

  always #5 clk = ~clk;

  // PRESENT entries and ready/valid exclusivity on the 10x10 loader.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mv10 && !mv10_prev) pres10 <= pres10 + 1;
      if (bus10.s_tready === mv10) viol10 <= viol10 + 1;
    end
    mv10_prev <= mv10;
  end

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic beat2(input logic [31:0] d, input logic l);
    int n = 0;
    bus2.s_tdata  = d;
    bus2.s_tlast  = l;
    bus2.s_tvalid = 1'b1;
    while (bus2.s_tready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("tready2_wait", {255'd0, bus2.s_tready}, 256'd1);
    @(negedge clk);
    bus2.s_tvalid = 1'b0;
    bus2.s_tlast  = 1'b0;
  endtask

  task automatic beat10(input logic [31:0] d, input logic l);
    int n = 0;
    bus10.s_tdata  = d;
    bus10.s_tlast  = l;
    bus10.s_tvalid = 1'b1;
    while (bus10.s_tready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("tready10_wait", {255'd0, bus10.s_tready}, 256'd1);
    @(negedge clk);
    bus10.s_tvalid = 1'b0;
    bus10.s_tlast  = 1'b0;
  endtask

  // f holds the six words in send order, first word in the top 32 bits.
  task automatic frame2(input logic [191:0] f, input logic gapped);
    for (int i = 0; i < 6; i++) begin
      beat2(f[191-32*i -: 32], (i == 5));
      if (gapped && i != 5) @(negedge clk);
    end
  endtask

  function automatic logic [31:0] w10(input int f, input int k);
    logic [7:0] fb, kb;
    fb = 8'(f);
    kb = 8'(k);
    return {8'h40, fb, 8'h11, kb};
  endfunction

  function automatic int mism10(input int f);
    int n = 0;
    for (int k = 0; k < 100; k++)
      if (m10[32*(100-k)-1 -: 32] !== w10(f, k)) n++;
    for (int k = 0; k < 10; k++)
      if (v10[32*(10-k)-1 -: 32] !== w10(f, 100 + k)) n++;
    return n;
  endfunction

  localparam logic [191:0] FA = 192'h41000000_40800000_40000000_3F800000_40A00000_40400000;
  localparam logic [191:0] FB = 192'h3F800000_40000000_40400000_40800000_40A00000_40C00000;
  localparam logic [191:0] FC = 192'h40E00000_41000000_41100000_41200000_41300000_41400000;
  localparam logic [191:0] FD = 192'hBF800000_C0000000_C0400000_C0800000_C0A00000_C0C00000;

  initial begin
    logic [191:0] f;
    rstn = 1'b1;
    rdy_m = 1'b1;
    rdy_v = 1'b1;
    bus2.s_tdata = '0;  bus2.s_tvalid = 1'b0;  bus2.s_tlast = 1'b0;
    bus10.s_tdata = '0; bus10.s_tvalid = 1'b0; bus10.s_tlast = 1'b0;
    #2 rstn = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_tready2", {255'd0, bus2.s_tready}, 256'd0);
    chk("rst_valid2",  {254'd0, mv2, vv2}, 256'd0);
    chk("rst_err2",    {255'd0, err2}, 256'd0);
    chk("rst_m2",      {128'd0, m2}, 256'd0);
    chk("rst_v2",      {192'd0, v2}, 256'd0);
    chk("rst_m10_any", {255'd0, |m10}, 256'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("tready2_after_rst", {255'd0, bus2.s_tready}, 256'd1);

    // Nominal 2x2 frame
    frame2(FA, 1'b0);
    chk("nom_valids", {254'd0, mv2, vv2}, 256'd3);
    chk("nom_tready", {255'd0, bus2.s_tready}, 256'd0);
    chk("nom_m2", {128'd0, m2}, {128'd0, FA[191:64]});
    chk("nom_v2", {192'd0, v2}, {192'd0, FA[63:0]});
    @(negedge clk);
    chk("nom_valids_drop", {254'd0, mv2, vv2}, 256'd0);
    chk("nom_tready_back", {255'd0, bus2.s_tready}, 256'd1);

    // Ready stall: vector ready low, briefly matrix ready low instead
    rdy_v = 1'b0;
    frame2(FB, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valids", {254'd0, mv2, vv2}, 256'd3);
      chk("stall_m2", {128'd0, m2}, {128'd0, FB[191:64]});
      chk("stall_v2", {192'd0, v2}, {192'd0, FB[63:0]});
      if (i == 2) begin rdy_m = 1'b0; rdy_v = 1'b1; end
      else        begin rdy_m = 1'b1; rdy_v = 1'b0; end
      @(negedge clk);
    end
    rdy_v = 1'b1;
    @(negedge clk);
    chk("stall_handoff", {254'd0, mv2, vv2}, 256'd0);
    chk("stall_tready", {255'd0, bus2.s_tready}, 256'd1);

    // Early tlast on word 3
    beat2(32'h11111111, 1'b0);
    beat2(32'h22222222, 1'b0);
    beat2(32'h33333333, 1'b1);
    chk("early_err", {255'd0, err2}, 256'd1);
    chk("early_valid", {255'd0, mv2}, 256'd0);
    @(negedge clk);
    chk("early_err_pulse", {255'd0, err2}, 256'd0);
    chk("early_tready", {255'd0, bus2.s_tready}, 256'd1);
    frame2(FC, 1'b0);
    chk("early_next_valid", {254'd0, mv2, vv2}, 256'd3);
    chk("early_next_m2", {128'd0, m2}, {128'd0, FC[191:64]});
    chk("early_next_v2", {192'd0, v2}, {192'd0, FC[63:0]});
    @(negedge clk);

    // Missing tlast, then two junk words closed by tlast
    f = FB;
    for (int i = 0; i < 6; i++) beat2(f[191-32*i -: 32], 1'b0);
    chk("miss_err", {255'd0, err2}, 256'd1);
    chk("miss_valid", {255'd0, mv2}, 256'd0);
    beat2(32'hDEADBEEF, 1'b0);
    chk("drain1_err", {255'd0, err2}, 256'd0);
    chk("drain1_valid", {255'd0, mv2}, 256'd0);
    beat2(32'hCAFEF00D, 1'b1);
    chk("drain2_err", {255'd0, err2}, 256'd0);
    chk("drain2_valid", {255'd0, mv2}, 256'd0);
    frame2(FD, 1'b0);
    chk("miss_next_valid", {254'd0, mv2, vv2}, 256'd3);
    chk("miss_next_m2", {128'd0, m2}, {128'd0, FD[191:64]});
    chk("miss_next_v2", {192'd0, v2}, {192'd0, FD[63:0]});
    @(negedge clk);

    // Gapped input
    frame2(FA, 1'b1);
    chk("gap_valid", {254'd0, mv2, vv2}, 256'd3);
    chk("gap_m2", {128'd0, m2}, {128'd0, FA[191:64]});
    chk("gap_v2", {192'd0, v2}, {192'd0, FA[63:0]});
    @(negedge clk);

    // Reset after word 4 of a 10x10 frame
    for (int k = 0; k < 4; k++) beat10(w10(0, k), 1'b0);
    chk("pre_rst_slot0", {224'd0, m10[3199 -: 32]}, {224'd0, w10(0, 0)});
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_m10_any", {255'd0, |m10}, 256'd0);
    chk("mid_rst_m2", {128'd0, m2}, 256'd0);
    chk("mid_rst_v2", {192'd0, v2}, 256'd0);
    chk("mid_rst_tready10", {255'd0, bus10.s_tready}, 256'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Two back-to-back 10x10 frames
    mon_en = 1'b1;
    for (int k = 0; k < 110; k++) beat10(w10(1, k), (k == 109));
    chk("b2b1_valid", {254'd0, mv10, vv10}, 256'd3);
    chk("b2b1_mism", 256'(mism10(1)), 256'd0);
    chk("b2b1_tready", {255'd0, bus10.s_tready}, 256'd0);
    for (int k = 0; k < 110; k++) beat10(w10(2, k), (k == 109));
    chk("b2b2_valid", {254'd0, mv10, vv10}, 256'd3);
    chk("b2b2_mism", 256'(mism10(2)), 256'd0);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_presents", 256'(pres10), 256'd2);
    chk("b2b_ready_excl", 256'(viol10), 256'd0);
    chk("b2b_err10", {255'd0, err10}, 256'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
